// File: rtl/shifter_pkg.sv
// shifter_pkg: mode and direction encodings plus the bit-reverse helper shared by the shifter.
package shifter_pkg;
    typedef enum logic [1:0] {
        LOGICAL = 2'b00,
        ARITH   = 2'b01,
        ROTATE  = 2'b10,
        ILLEGAL = 2'b11
    } mode_t;
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;
    localparam int   MAX_W     = 64;
    function automatic logic [MAX_W-1:0] bit_rev(input logic [MAX_W-1:0] v, input int w);
        bit_rev = '0;
        for (int i = 0; i < MAX_W; i++)
            if (i < w) bit_rev[i] = v[w-1-i];
    endfunction
endpackage

// File: rtl/barrel_shift_stage.sv
// barrel_shift_stage: one registered left shift by SHIFT (when its amt bit is set) with valid/ready hold.
module barrel_shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHIFT = 1,
    parameter int TAG_W = 4,
    localparam int AW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AW-1:0]    in_amt,
    input  logic             in_dir,
    input  logic [1:0]       in_mode,
    input  logic             in_sign,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             in_err,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [AW-1:0]    out_amt,
    output logic             out_dir,
    output logic [1:0]       out_mode,
    output logic             out_sign,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);
    localparam int K = $clog2(SHIFT);
    logic [SHIFT-1:0] fill;
    logic [WIDTH-1:0] shifted;
`ifdef SHIFTER_ROTATE_EN
    assign fill = (in_mode == ROTATE) ? in_data[WIDTH-1 -: SHIFT] : {SHIFT{in_sign}};
`else
    assign fill = {SHIFT{in_sign}};
`endif
    assign shifted  = in_amt[K] ? {in_data[WIDTH-SHIFT-1:0], fill} : in_data;
    assign in_ready = !out_valid || out_ready;
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_amt   <= '0;
            out_dir   <= 1'b0;
            out_mode  <= '0;
            out_sign  <= 1'b0;
            out_tag   <= '0;
            out_err   <= 1'b0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= shifted;
                out_amt  <= in_amt;
                out_dir  <= in_dir;
                out_mode <= in_mode;
                out_sign <= in_sign;
                out_tag  <= in_tag;
                out_err  <= in_err;
            end
        end
    end
endmodule

// File: rtl/barrel_shifter_pipe.sv
// barrel_shifter_pipe: pipelined logical/arithmetic/rotate barrel shifter; rotate enabled by SHIFTER_ROTATE_EN.
module barrel_shifter_pipe
    import shifter_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int TAG_W  = 4,
    localparam int NSTG  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [NSTG-1:0]  in_amt,
    input  logic             in_dir,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);
    logic             v    [NSTG+1];
    logic             rdy  [NSTG+1];
    logic [WIDTH-1:0] d    [NSTG+1];
    logic [NSTG-1:0]  a    [NSTG+1];
    logic             dir  [NSTG+1];
    logic [1:0]       m    [NSTG+1];
    logic             sgn  [NSTG+1];
    logic [TAG_W-1:0] t    [NSTG+1];
    logic             err  [NSTG+1];
    logic             unused_ok;
    assign v[0]   = in_valid;
    assign d[0]   = (in_dir == DIR_RIGHT) ? WIDTH'(bit_rev(MAX_W'(in_data), WIDTH)) : in_data;
    assign a[0]   = in_amt;
    assign dir[0] = in_dir;
    assign m[0]   = in_mode;
    assign sgn[0] = (in_mode == ARITH) && (in_dir == DIR_RIGHT) && in_data[WIDTH-1];
    assign t[0]   = in_tag;
`ifdef SHIFTER_ROTATE_EN
    assign err[0] = in_mode == ILLEGAL;
`else
    assign err[0] = in_mode[1];
`endif
    assign in_ready  = rdy[0];
    assign rdy[NSTG] = out_ready;
    for (genvar i = 0; i < NSTG; i++) begin : g_stg
        barrel_shift_stage #(
            .WIDTH (WIDTH),
            .SHIFT (1 << i),
            .TAG_W (TAG_W)
        ) u_stg (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (v[i]),
            .in_ready  (rdy[i]),
            .in_data   (d[i]),
            .in_amt    (a[i]),
            .in_dir    (dir[i]),
            .in_mode   (m[i]),
            .in_sign   (sgn[i]),
            .in_tag    (t[i]),
            .in_err    (err[i]),
            .out_valid (v[i+1]),
            .out_ready (rdy[i+1]),
            .out_data  (d[i+1]),
            .out_amt   (a[i+1]),
            .out_dir   (dir[i+1]),
            .out_mode  (m[i+1]),
            .out_sign  (sgn[i+1]),
            .out_tag   (t[i+1]),
            .out_err   (err[i+1])
        );
    end
    assign out_valid = v[NSTG];
    assign out_data  = (dir[NSTG] == DIR_RIGHT) ? WIDTH'(bit_rev(MAX_W'(d[NSTG]), WIDTH)) : d[NSTG];
    assign out_tag   = t[NSTG];
    assign out_err   = err[NSTG];
    assign unused_ok = ^{a[NSTG], m[NSTG], sgn[NSTG]};
endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// tb_barrel_shifter_pipe: scoreboard bench with directed vectors for barrel_shifter_pipe.
module tb_barrel_shifter_pipe;
    localparam int NSTG = 3;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic [2:0] in_amt = '0;
    logic       in_dir = 1'b0;
    logic [1:0] in_mode = '0;
    logic [3:0] in_tag = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic [3:0] out_tag;
    logic       out_err;

    typedef struct {
        logic [7:0] d;
        logic [3:0] t;
        logic       e;
        int         acc;
        bit         lat;
    } exp_t;
    exp_t sb[$];
    int tests = 0, fails = 0, cyc = 0, acc_cnt = 0;
    bit prev_stall = 0;
    logic [7:0] held_d;
    logic [3:0] held_t;

    barrel_shifter_pipe #(.WIDTH(8), .TAG_W(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_amt(in_amt), .in_dir(in_dir), .in_mode(in_mode),
        .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag), .out_err(out_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic [2:0] a, input logic dr, input logic [1:0] m,
                        input logic [3:0] t, input logic [7:0] ed, input logic ee, input bit lat,
                        output int waited);
        exp_t e;
        in_valid = 1'b1; in_data = d; in_amt = a; in_dir = dr; in_mode = m; in_tag = t;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!in_ready && waited < 200);
        if (!in_ready) begin
            chk("send_timeout", 32'(in_ready), 32'd1);
        end else begin
            e.d = ed; e.t = t; e.e = ee; e.acc = cyc + 1; e.lat = lat;
            sb.push_back(e);
            acc_cnt++;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 0;
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 32'(out_tag), 32'hFFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_data", 32'(out_data), 32'(e.d));
                    chk("out_tag", 32'(out_tag), 32'(e.t));
                    chk("out_err", 32'(out_err), 32'(e.e));
                    if (e.lat) chk("latency", 32'(cyc + 1 - e.acc), NSTG);
                end
            end
            if (out_valid && !out_ready) begin
                if (prev_stall) begin
                    chk("stall_data_hold", 32'(out_data), 32'(held_d));
                    chk("stall_tag_hold", 32'(out_tag), 32'(held_t));
                end
                held_d = out_data; held_t = out_tag; prev_stall = 1;
            end else begin
                prev_stall = 0;
            end
        end
    end

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int w, base;
        logic [7:0] rl, rr;
        logic       re;
        logic [7:0] stream_exp [8];
        stream_exp[0] = 8'h96; stream_exp[1] = 8'h2C; stream_exp[2] = 8'h58; stream_exp[3] = 8'hB0;
        stream_exp[4] = 8'h60; stream_exp[5] = 8'hC0; stream_exp[6] = 8'h80; stream_exp[7] = 8'h00;
`ifdef SHIFTER_ROTATE_EN
        rl = 8'hB4; rr = 8'hD2; re = 1'b0;
`else
        rl = 8'hB0; rr = 8'h12; re = 1'b1;
`endif
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        @(posedge clk); #1;

        send(8'h96, 3'd3, 1'b0, 2'b00, 4'd1, 8'hB0, 1'b0, 1, w); drain();
        send(8'h96, 3'd3, 1'b1, 2'b00, 4'd2, 8'h12, 1'b0, 1, w); drain();
        send(8'h96, 3'd3, 1'b1, 2'b01, 4'd3, 8'hF2, 1'b0, 1, w); drain();
        send(8'h16, 3'd3, 1'b1, 2'b01, 4'd4, 8'h02, 1'b0, 1, w); drain();
        send(8'h96, 3'd3, 1'b0, 2'b01, 4'd5, 8'hB0, 1'b0, 1, w); drain();
        send(8'h96, 3'd3, 1'b0, 2'b10, 4'd6, rl,    re,   1, w); drain();
        send(8'h96, 3'd3, 1'b1, 2'b10, 4'd7, rr,    re,   1, w); drain();
        send(8'h96, 3'd3, 1'b0, 2'b11, 4'd8, 8'hB0, 1'b1, 1, w); drain();
        send(8'h96, 3'd3, 1'b1, 2'b11, 4'd9, 8'h12, 1'b1, 1, w); drain();
        send(8'h96, 3'd0, 1'b1, 2'b00, 4'hA, 8'h96, 1'b0, 1, w);
        send(8'h96, 3'd0, 1'b1, 2'b01, 4'hB, 8'h96, 1'b0, 1, w);
        send(8'h96, 3'd0, 1'b1, 2'b10, 4'hC, 8'h96, re,   1, w);
        send(8'h96, 3'd0, 1'b0, 2'b11, 4'hD, 8'h96, 1'b1, 1, w);
        drain();
        send(8'h80, 3'd7, 1'b1, 2'b01, 4'hE, 8'hFF, 1'b0, 1, w); drain();

        for (int i = 0; i < 8; i++) begin
            send(8'h96, 3'(i), 1'b0, 2'b00, 4'(i), stream_exp[i], 1'b0, 1, w);
            chk("stream_in_ready", 32'(w), 32'd1);
        end
        drain();

        out_ready = 1'b0;
        base = acc_cnt;
        fork
            begin
                send(8'h80, 3'd1, 1'b1, 2'b01, 4'h8, 8'hC0, 1'b0, 0, w);
                send(8'h80, 3'd7, 1'b1, 2'b01, 4'h9, 8'hFF, 1'b0, 0, w);
                send(8'h7F, 3'd2, 1'b1, 2'b01, 4'hA, 8'h1F, 1'b0, 0, w);
                send(8'hF0, 3'd4, 1'b1, 2'b00, 4'hB, 8'h0F, 1'b0, 0, w);
            end
            begin
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b1;
            end
            begin
                repeat (4) @(negedge clk);
                chk("stall_in_ready_low", 32'(in_ready), 32'd0);
                chk("stall_accepts", 32'(acc_cnt - base), 32'd3);
            end
        join
        drain();

        out_ready = 1'b0;
        send(8'h96, 3'd3, 1'b0, 2'b00, 4'h5, 8'hB0, 1'b0, 0, w);
        send(8'h96, 3'd3, 1'b1, 2'b00, 4'h6, 8'h12, 1'b0, 0, w);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        sb.delete();
        out_ready = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        repeat (8) @(posedge clk);
        #1;
        send(8'h16, 3'd3, 1'b1, 2'b01, 4'h3, 8'h02, 1'b0, 1, w);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/barrel_shifter_pipe.md
# barrel_shifter_pipe

Parametrised, pipelined bidirectional barrel shifter with valid/ready handshake on both sides. It supports logical shift, arithmetic shift and rotate in either direction. Data width, and therefore stage count, is set by parameter, and a sideband tag travels with each word. It sits between a producer (ALU front end, UART/LED datapath) and a consumer that may stall, and sustains one shift per clock.

## Interface
- `WIDTH`, 8: data width; power of two, ≥ 2.
- `TAG_W`, 4: sideband tag width, passed through unchanged; ≥ 1.
- `NSTG`, derived = $clog2(WIDTH): number of shift stages; also the latency.

- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input word present.
- `in_ready`  out  1  block can accept the input word this cycle.
- `in_data`  in  WIDTH  operand.
- `in_amt`  in  NSTG  shift amount, 0..WIDTH-1.
- `in_dir`  in  1  0 = left, 1 = right.
- `in_mode`  in  2  00 logical, 01 arithmetic, 10 rotate, 11 illegal.
- `in_tag`  in  TAG_W  sideband.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  WIDTH  shifted result.
- `out_tag`  out  TAG_W  tag of the result.
- `out_err`  out  1  result came from an illegal or disabled mode.

## Operation
- Transfer occurs on either side when valid && ready are both high at a rising edge.
- Direction handling:
  - For right shifts, the operand is bit-reversed on entry.
  - The operand is then shifted left through NSTG stages.
  - The result is bit-reversed again on exit.
- Stage k shifts by 2^k when `amt[k]` = 1; otherwise it passes the word through.
- Fill bit per stage:
  - Logical: 0.
  - Arithmetic right: the original `in_data[WIDTH-1]`, captured at entry and carried down the pipe.
  - Arithmetic left: 0, identical to logical.
  - Rotate: the bits shifted out wrap around.
- Mode 11 produces a logical shift of the same data with `out_err` = 1.
- Each stage register holds: valid, data, remaining amt bits, dir, mode, sign, tag, err.
- Advance rule: stage k loads when stage k is empty or stage k is unloading into stage k+1, or to the output when k is last.
- `in_ready` = !v[0] || adv[0], a purely combinational function of register state and `out_ready`.
  - There is no combinational path from `in_valid` to `in_ready`.
- Zero-bubble pipeline: with `out_ready` held high, one result per clock.
- Stall: with `out_ready` low, the pipe fills. After NSTG accepted words `in_ready` drops, and all held words stay stable.
- `amt` = 0 returns `in_data` unchanged in every mode.
- Results are in order; tag and err stay aligned to their data.

## Timing
- Latency: a word accepted at edge n appears with `out_valid` = 1 after edge n+NSTG, provided there is no stall.
- While `out_valid` && !`out_ready`, `out_data`, `out_tag` and `out_err` hold stable.
- Reset values:
  - Effect: every stage valid bit is cleared, so `out_valid` = 0 and `in_ready` = 1 from the first post-reset cycle.
  - `out_data` = 0, `out_tag` = 0, `out_err` = 0.
- Reset mid-operation discards all in-flight words. No partial output is emitted.
- Simultaneous accept and emit in a full pipe is legal and keeps occupancy constant.

## Configuration
- `SHIFTER_ROTATE_EN` defined:
  - Mode 10 rotates as described.
  - `out_err` is set only for mode 11.
- `SHIFTER_ROTATE_EN` undefined:
  - Rotate logic is omitted from the stages.
  - Mode 10 is treated like mode 11: logical shift with `out_err` = 1.
- The port list is identical in both builds.

## Structure
- Package `shifter_pkg` holds:
  - the mode encoding (LOGICAL, ARITH, ROTATE, ILLEGAL) as a 2-bit typedef;
  - a direction localparam pair;
  - the function computing the bit-reverse of a WIDTH vector.
- Sub-module `barrel_shift_stage`, parameters WIDTH and SHIFT = 2^k:
  - holds one registered stage with its handshake and fill logic;
  - the top generates NSTG instances and the entry/exit bit-reversal.

## Test plan
- WIDTH=8, `in_data`=0x96, amt=3, logical:
  - left → 0xB0;
  - right → 0x12.
  - Each result arrives 3 cycles after accept.
- 0x96, amt=3, arithmetic right → 0xF2. 0x16, amt=3, arithmetic right → 0x02.
- 0x96, amt=3, rotate left → 0xB4, rotate right → 0xD2 (macro defined). With the macro undefined, both give the logical result with `out_err` = 1.
- Stream of 8 words, `out_ready` = 1 → 8 consecutive results, tags 0..7 in order, `in_ready` never low.
- `out_ready` = 0 for 6 cycles while feeding:
  - `in_ready` drops after 3 accepts;
  - `out_data` holds stable;
  - on release, all words drain in order with no loss or duplication.
- `reset` asserted with 2 words in flight → next cycle `out_valid` = 0 and `in_ready` = 1; no stale word emerges afterwards.
